// File: rtl/in_debounce_pkg.sv
// Shared types and default constants for the in_debounce input conditioner.
package in_debounce_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_GLITCH_W      = 8;

    typedef enum logic [1:0] {
        IDLE_LOW,
        CONFIRM_HIGH,
        IDLE_HIGH,
        CONFIRM_LOW
    } deb_state_e;

    function automatic logic isConfirm(input deb_state_e s);
        return (s == CONFIRM_HIGH) || (s == CONFIRM_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for one asynchronous bit; depth set by STAGES (>= 2).
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/in_debounce.sv
// Synchronizer plus confirm FSM that only passes levels stable for STABLE_CYCLES samples.
// Optional edge pulse outputs are enabled by defining IN_DEBOUNCE_EDGE_EN.
module in_debounce
    import in_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int GLITCH_W      = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
`ifdef IN_DEBOUNCE_EDGE_EN
    ,
    output logic                rise_pulse,
    output logic                fall_pulse
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : gBadSync
        $error("in_debounce: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : gBadStable
        $error("in_debounce: STABLE_CYCLES must be at least 1");
    end

    logic                sync_q;
    deb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_q, out_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    sync_2ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (raw_in),
        .q_o  (sync_q)
    );

    // cnt holds how many matching samples the pending level has collected so far.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = glitch_q;
        case (state_q)
            IDLE_LOW: begin
                if (sync_q) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = IDLE_HIGH;
                        out_d   = 1'b1;
                    end else begin
                        state_d = CONFIRM_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CONFIRM_HIGH: begin
                if (!sync_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    if (glitch_q != '1) glitch_d = glitch_q + GLITCH_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_q) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = IDLE_LOW;
                        out_d   = 1'b0;
                    end else begin
                        state_d = CONFIRM_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CONFIRM_LOW: begin
                if (sync_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    if (glitch_q != '1) glitch_d = glitch_q + GLITCH_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE_LOW;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

`ifdef IN_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`endif

    assign out        = out_q;
    assign busy       = isConfirm(state_q);
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_in_debounce.sv
// Scoreboard bench for in_debounce: run-length reference model feeds an expected queue, a monitor compares.
module tb_in_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int GW     = 8;
    localparam int GMAX   = (1 << GW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          rawIn = 1'b0;
    logic          out;
    logic          busy;
    logic [GW-1:0] glitchCnt;
`ifdef IN_DEBOUNCE_EDGE_EN
    logic          risePulse;
    logic          fallPulse;
`endif

    in_debounce #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .GLITCH_W     (GW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (rawIn),
        .out       (out),
        .busy      (busy),
        .glitch_cnt(glitchCnt)
`ifdef IN_DEBOUNCE_EDGE_EN
        ,
        .rise_pulse(risePulse),
        .fall_pulse(fallPulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic out;
        logic busy;
        int   glitch;
        logic rise;
        logic fall;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: raw samples travel through a SYNC-long delay line, then a
    // run of samples disagreeing with the output either reaches STABLE (output flips)
    // or is broken early (one glitch).
    logic delayLine[$];
    logic mOut;
    int   run;
    int   mGlitch;

    task automatic modelReset();
        delayLine = {};
        for (int i = 0; i < SYNC; i++) delayLine.push_back(1'b0);
        mOut    = 1'b0;
        run     = 0;
        mGlitch = 0;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rst);
        exp_t e;
        logic prevOut;
        logic fsmIn;
        @(negedge clk);
        rawIn   = r;
        reset   = rst;
        prevOut = mOut;
        e.rise  = 1'b0;
        e.fall  = 1'b0;
        if (rst) begin
            modelReset();
        end else begin
            fsmIn = delayLine.pop_front();
            delayLine.push_back(r);
            if (fsmIn != mOut) begin
                run++;
                if (run >= STABLE) begin
                    mOut = fsmIn;
                    run  = 0;
                end
            end else if (run > 0) begin
                if (mGlitch < GMAX) mGlitch++;
                run = 0;
            end
            e.rise = !prevOut && mOut;
            e.fall = prevOut && !mOut;
        end
        e.out    = mOut;
        e.busy   = (run > 0);
        e.glitch = mGlitch;
        expQ.push_back(e);
    endtask

    task automatic holdLevel(input logic r, input int n);
        for (int i = 0; i < n; i++) applyStimulus(r, 1'b0);
    endtask

    // Monitor: one expected entry is consumed per clock edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("out", int'(out), int'(e.out));
                checkOutput("busy", int'(busy), int'(e.busy));
                checkOutput("glitch_cnt", int'(glitchCnt), e.glitch);
`ifdef IN_DEBOUNCE_EDGE_EN
                checkOutput("rise_pulse", int'(risePulse), int'(e.rise));
                checkOutput("fall_pulse", int'(fallPulse), int'(e.fall));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        logic lvl;
        modelReset();

        // Reset held with raw_in high, then full latency after release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        holdLevel(1'b1, 10);

        // Clean fall and rise.
        holdLevel(1'b0, 20);
        holdLevel(1'b1, 20);
        holdLevel(1'b0, 20);

        // Short pulses until the glitch counter saturates.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            holdLevel(1'b1, 3);
            holdLevel(1'b0, 5);
        end
        @(posedge clk);
        #2;
        checkOutput("glitch_saturated", int'(glitchCnt), GMAX);

        // Reset pulsed while confirming a rise.
        holdLevel(1'b1, 4);
        applyStimulus(1'b1, 1'b1);
        holdLevel(1'b1, 10);
        holdLevel(1'b0, 10);

        // Randomized level runs with occasional resets.
        lvl = 1'b0;
        for (int i = 0; i < 250; i++) begin
            len = $urandom_range(1, 8);
            lvl = ~lvl;
            holdLevel(lvl, len);
            if ($urandom_range(0, 39) == 0) applyStimulus(lvl, 1'b1);
        end
        holdLevel(1'b0, 10);

        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
